// File: rtl/semaforo_pkg.sv
// Shared encodings for the traffic-light monitor: FSM states, lamp codes
// {rojo,amarillo,verde} and the legal colour sequence.
package semaforo_pkg;

  typedef enum logic [1:0] {
    ST_SYNC     = 2'd0,
    ST_ROJO     = 2'd1,
    ST_VERDE    = 2'd2,
    ST_AMARILLO = 2'd3
  } state_t;

  localparam logic [2:0] LAMP_NONE = 3'b000;
  localparam logic [2:0] LAMP_R    = 3'b100;
  localparam logic [2:0] LAMP_A    = 3'b010;
  localparam logic [2:0] LAMP_V    = 3'b001;

  // Legal successor: rojo -> verde -> amarillo -> rojo.
  function automatic logic [2:0] siguiente(input logic [2:0] code);
    case (code)
      LAMP_R:  siguiente = LAMP_V;
      LAMP_V:  siguiente = LAMP_A;
      LAMP_A:  siguiente = LAMP_R;
      default: siguiente = LAMP_NONE;
    endcase
  endfunction

  function automatic state_t estado_de(input logic [2:0] code);
    case (code)
      LAMP_R:  estado_de = ST_ROJO;
      LAMP_V:  estado_de = ST_VERDE;
      LAMP_A:  estado_de = ST_AMARILLO;
      default: estado_de = ST_SYNC;
    endcase
  endfunction

endpackage

// File: rtl/semaforo_monitor.sv
// Passive checker for the traffic-light lamps: one-hot, colour order and
// per-colour dwell; registered error pulses, sticky flag and clean-cycle count.
module semaforo_monitor
  import semaforo_pkg::*;
#(
  parameter int T_ROJO     = 4,
  parameter int T_VERDE    = 3,
  parameter int T_AMARILLO = 2,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rojo,
  input  logic             amarillo,
  input  logic             verde,
  output logic             sincronizado,
  output logic             err_onehot,
  output logic             err_orden,
  output logic             err_duracion,
  output logic             err_sticky,
  output logic [CNT_W-1:0] ciclos_ok,
  output state_t           dbg_state
);

  localparam int T_MAX0 = (T_ROJO > T_VERDE) ? T_ROJO : T_VERDE;
  localparam int T_MAX  = (T_MAX0 > T_AMARILLO) ? T_MAX0 : T_AMARILLO;
  localparam int DW     = $clog2(T_MAX + 2);

  localparam logic [DW-1:0] D_SAT = DW'(T_MAX + 1);
  localparam logic [DW-1:0] D_R   = DW'(T_ROJO);
  localparam logic [DW-1:0] D_V   = DW'(T_VERDE);
  localparam logic [DW-1:0] D_A   = DW'(T_AMARILLO);

  state_t        state, nxt_state;
  logic [2:0]    prev, nxt_prev;
  logic [DW-1:0] dwell, nxt_dwell, dwell_inc, t_cur;
  logic          limpio, nxt_limpio;
  logic          p_onehot, p_orden, p_duracion, p_ciclo;
  logic [2:0]    code;
  logic          code_ok;

  assign code      = {rojo, amarillo, verde};
  assign code_ok   = (code == LAMP_R) || (code == LAMP_A) || (code == LAMP_V);
  assign dwell_inc = (dwell == D_SAT) ? D_SAT : dwell + DW'(1);
  assign dbg_state = state;

  always_comb begin
    case (state)
      ST_ROJO:     t_cur = D_R;
      ST_VERDE:    t_cur = D_V;
      ST_AMARILLO: t_cur = D_A;
      default:     t_cur = D_SAT;
    endcase
  end

  always_comb begin
    nxt_state  = state;
    nxt_prev   = code;
    nxt_dwell  = dwell_inc;
    nxt_limpio = limpio;
    p_onehot   = 1'b0;
    p_orden    = 1'b0;
    p_duracion = 1'b0;
    p_ciclo    = 1'b0;
    if (!code_ok) begin
      p_onehot   = 1'b1;
      nxt_state  = ST_SYNC;
      nxt_prev   = LAMP_NONE;
      nxt_dwell  = '0;
      nxt_limpio = 1'b0;
    end else if (state == ST_SYNC) begin
      nxt_limpio = 1'b0;
      if (code != prev) begin
        nxt_dwell = DW'(1);
        // A change out of 000 is not a phase boundary; keep waiting.
        if (prev != LAMP_NONE) nxt_state = estado_de(code);
      end
    end else if (code == prev) begin
      if (dwell_inc == t_cur + DW'(1)) begin
        p_duracion = 1'b1;
        nxt_state  = ST_SYNC;
        nxt_limpio = 1'b0;
      end
    end else begin
      nxt_dwell = DW'(1);
      if (code != siguiente(prev)) begin
        p_orden    = 1'b1;
        nxt_state  = ST_SYNC;
        nxt_limpio = 1'b0;
      end else if (dwell < t_cur) begin
        p_duracion = 1'b1;
        nxt_state  = ST_SYNC;
        nxt_limpio = 1'b0;
      end else begin
        nxt_state = estado_de(code);
        if (prev == LAMP_R) nxt_limpio = 1'b1;
        if (prev == LAMP_A && limpio) p_ciclo = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_SYNC;
      prev   <= LAMP_NONE;
      dwell  <= '0;
      limpio <= 1'b0;
    end else begin
      state  <= nxt_state;
      prev   <= nxt_prev;
      dwell  <= nxt_dwell;
      limpio <= nxt_limpio;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sincronizado <= 1'b0;
      err_onehot   <= 1'b0;
      err_orden    <= 1'b0;
      err_duracion <= 1'b0;
      err_sticky   <= 1'b0;
      ciclos_ok    <= '0;
    end else begin
      sincronizado <= (nxt_state != ST_SYNC);
      err_onehot   <= p_onehot;
      err_orden    <= p_orden;
      err_duracion <= p_duracion;
      err_sticky   <= err_sticky | p_onehot | p_orden | p_duracion;
      if (p_ciclo && ciclos_ok != '1) ciclos_ok <= ciclos_ok + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_semaforo_monitor.sv
// Table-driven bench for semaforo_monitor: lamp runs with expected outputs,
// a scoreboard queue, and a hand-written async-reset sequence mid-amarillo.
module tb_semaforo_monitor;
  import semaforo_pkg::*;

  localparam int W = 13;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rojo = 1'b0, amarillo = 1'b0, verde = 1'b0;
  logic       sincronizado, err_onehot, err_orden, err_duracion, err_sticky;
  logic [7:0] ciclos_ok;
  state_t     dbg_state;

  semaforo_monitor dut (
    .clk(clk), .rst(rst), .rojo(rojo), .amarillo(amarillo), .verde(verde),
    .sincronizado(sincronizado), .err_onehot(err_onehot), .err_orden(err_orden),
    .err_duracion(err_duracion), .err_sticky(err_sticky), .ciclos_ok(ciclos_ok),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // One record = a run of n identical samples, all expecting the same outputs.
  // n == 0 marks an asynchronous reset pulse instead of a run.
  typedef struct {
    logic [2:0]   code;
    int           n;
    logic [W-1:0] exp;
  } vec_t;

  vec_t         tbl[$];
  logic [W-1:0] exp_q[$];
  int           checks = 0;
  int           errors = 0;

  localparam logic [2:0] R = 3'b100, A = 3'b010, V = 3'b001, X = 3'b110;

  function automatic void add(input logic [2:0] code, input int n, input logic s,
                              input logic oh, input logic ord, input logic du,
                              input logic st, input int c);
    vec_t r;
    r.code = code;
    r.n    = n;
    r.exp  = {s, oh, ord, du, st, 8'(c)};
    tbl.push_back(r);
  endfunction

  function automatic logic [W-1:0] actual();
    return {sincronizado, err_onehot, err_orden, err_duracion, err_sticky, ciclos_ok};
  endfunction

  task automatic compare(input string name, input int idx, input logic [W-1:0] got);
    logic [W-1:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s row %0d: scoreboard empty, got %b", name, idx, got);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        errors++;
        $display("FAIL %s row %0d: got {s,oh,ord,du,st,ciclos}=%b expected %b",
                 name, idx, got, e);
      end
    end
  endtask

  task automatic step(input logic [2:0] code, input logic [W-1:0] exp, input int idx);
    @(negedge clk);
    {rojo, amarillo, verde} = code;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    compare("sample", idx, actual());
  endtask

  task automatic async_reset(input int idx);
    @(negedge clk);
    rst = 1'b1;
    exp_q.push_back('0);
    #1;
    compare("async_rst", idx, actual());
    checks++;
    if (dbg_state !== ST_SYNC) begin
      errors++;
      $display("FAIL async_rst_state row %0d: got %0d expected %0d", idx, dbg_state, ST_SYNC);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    // Clean run: partial rojo, then R4 V3 A2 three times.
    add(R, 3, 0, 0, 0, 0, 0, 0);
    add(V, 3, 1, 0, 0, 0, 0, 0);
    add(A, 2, 1, 0, 0, 0, 0, 0);
    add(R, 4, 1, 0, 0, 0, 0, 0);
    add(V, 3, 1, 0, 0, 0, 0, 0);
    add(A, 2, 1, 0, 0, 0, 0, 0);
    add(R, 4, 1, 0, 0, 0, 0, 1);
    add(V, 3, 1, 0, 0, 0, 0, 1);
    add(A, 2, 1, 0, 0, 0, 0, 1);
    add(R, 4, 1, 0, 0, 0, 0, 2);
    // Short verde.
    add(V, 2, 1, 0, 0, 0, 0, 2);
    add(A, 1, 0, 0, 0, 1, 1, 2);
    add(A, 1, 0, 0, 0, 0, 1, 2);
    // Stuck rojo for 6 samples.
    add(R, 4, 1, 0, 0, 0, 1, 2);
    add(R, 1, 0, 0, 0, 1, 1, 2);
    add(R, 1, 0, 0, 0, 0, 1, 2);
    // Illegal order rojo -> amarillo, then resync.
    add(V, 3, 1, 0, 0, 0, 1, 2);
    add(A, 2, 1, 0, 0, 0, 1, 2);
    add(R, 4, 1, 0, 0, 0, 1, 2);
    add(A, 1, 0, 0, 1, 0, 1, 2);
    add(A, 1, 0, 0, 0, 0, 1, 2);
    add(R, 4, 1, 0, 0, 0, 1, 2);
    // Two lamps on mid-verde.
    add(V, 2, 1, 0, 0, 0, 1, 2);
    add(X, 1, 0, 1, 0, 0, 1, 2);
    add(V, 2, 0, 0, 0, 0, 1, 2);
    add(A, 1, 1, 0, 0, 0, 1, 2);
    // Reset mid-amarillo; first phase afterwards is unchecked.
    add(A, 0, 0, 0, 0, 0, 0, 0);
    add(A, 1, 0, 0, 0, 0, 0, 0);
    add(R, 4, 1, 0, 0, 0, 0, 0);
    add(V, 3, 1, 0, 0, 0, 0, 0);
    add(A, 2, 1, 0, 0, 0, 0, 0);
    add(R, 1, 1, 0, 0, 0, 0, 1);

    // Initial reset: outputs must be cleared without any clock edge.
    #1 rst = 1'b1;
    exp_q.push_back('0);
    #1;
    compare("reset", -1, actual());
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].n == 0) async_reset(i);
      else for (int k = 0; k < tbl[i].n; k++) step(tbl[i].code, tbl[i].exp, i);
    end

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
